// File: rtl/n_bit_serial_subtractor.sv
// n_bit_serial_subtractor: bit-serial a - b with borrow/overflow flags over a start/done handshake.
// Define SERIAL_SUB_RADIX4_EN to retire two bits per RUN cycle (N must be even).
module n_bit_serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         overflow,
    output logic         done_valid,
    input  logic         done_ready
);
`ifdef SERIAL_SUB_RADIX4_EN
    localparam int STEP = 2;
    if (N % 2 != 0) begin : g_odd_n
        $error("n_bit_serial_subtractor: N must be even with SERIAL_SUB_RADIX4_EN");
    end
`else
    localparam int STEP = 1;
`endif
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N / STEP - 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  a_sr, b_sr, d_sr, d_nx, ins;
    logic [CW-1:0] cnt;
    logic          br, br1, br_nx, a_msb, b_msb;

    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);

    // Difference bits enter at the MSB end so bit 0 lands at d_sr[0] after the last shift.
    always_comb begin
        br1 = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        ins = '0;
`ifdef SERIAL_SUB_RADIX4_EN
        ins[N-1] = a_sr[1] ^ b_sr[1] ^ br1;
        ins[N-2] = a_sr[0] ^ b_sr[0] ^ br;
        br_nx    = (~a_sr[1] & b_sr[1]) | (~(a_sr[1] ^ b_sr[1]) & br1);
`else
        ins[N-1] = a_sr[0] ^ b_sr[0] ^ br;
        br_nx    = br1;
`endif
        d_nx = (d_sr >> STEP) | ins;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    a_msb <= a[N-1];
                    b_msb <= b[N-1];
                    br    <= 1'b0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sr <= a_sr >> STEP;
                    b_sr <= b_sr >> STEP;
                    d_sr <= d_nx;
                    br   <= br_nx;
                    cnt  <= cnt + 1'b1;
                    // Outputs are a shadow copy, refreshed only on entry to DONE.
                    if (cnt == LAST) begin
                        state      <= DONE;
                        diff       <= d_nx;
                        borrow_out <= br_nx;
                        overflow   <= (a_msb != b_msb) && (d_nx[N-1] != a_msb);
                    end
                end
                DONE: if (done_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
